// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the 2-read/1-write register file with scoreboard.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;
  localparam int unsigned ZERO_ADDR      = 0;

  function automatic int unsigned nregs(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: claims set a bit, writes clear it, re-claims of a
// still-pending register raise a one-cycle conflict pulse.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned NREGS    = nregs(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic [NREGS-1:0]  pending,
  output logic              claim_conflict
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic             conflict_q, conflict_d;
  logic             wr_ok, claim_ok;

  assign wr_ok    = wr_en    && !((ZERO_REG != 0) && (wr_addr    == ADDR_W'(ZERO_ADDR)));
  assign claim_ok = claim_en && !((ZERO_REG != 0) && (claim_addr == ADDR_W'(ZERO_ADDR)));

  // Clear first, then set, so a same-cycle claim beats the retiring write.
  always_comb begin
    pending_d  = pending_q;
    conflict_d = 1'b0;
    if (wr_ok) begin
      pending_d[wr_addr] = 1'b0;
    end
    if (claim_ok) begin
      pending_d[claim_addr] = 1'b1;
      conflict_d = pending_q[claim_addr] && !(wr_ok && (wr_addr == claim_addr));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      conflict_q <= conflict_d;
    end
  end

  assign pending        = pending_q;
  assign claim_conflict = conflict_q;

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Register file, two registered read ports and one write port, with optional
// write-to-read bypass, hardwired zero register and a pending-write scoreboard.
module regfile_2r1w_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter  int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter  int unsigned ZERO_REG = 1,
  parameter  int unsigned BYPASS   = 1,
  localparam int unsigned NREGS    = nregs(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid,
  output logic              busy1,
  output logic              busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              claim_conflict,
  output logic [NREGS-1:0]  pending
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];
  logic [1:0]        busy_q, busy_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] raddr [2];
  logic              wr_ok;

  assign raddr[0] = rd_addr1;
  assign raddr[1] = rd_addr2;
  assign wr_ok    = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_ADDR)));

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .claim_en       (claim_en),
    .claim_addr     (claim_addr),
    .pending        (pending),
    .claim_conflict (claim_conflict)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Busy after a bypassed write is only the same-cycle claim of a new writer.
  always_comb begin
    logic is_zero, wr_hit, claim_hit;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    rd_valid_d = rd_en;
    is_zero    = 1'b0;
    wr_hit     = 1'b0;
    claim_hit  = 1'b0;
    for (int p = 0; p < 2; p++) begin
      is_zero   = (ZERO_REG != 0) && (raddr[p] == ADDR_W'(ZERO_ADDR));
      wr_hit    = (BYPASS != 0) && wr_en && (wr_addr == raddr[p]);
      claim_hit = claim_en && (claim_addr == raddr[p]);
      if (rd_en) begin
        if (is_zero) begin
          rdata_d[p] = '0;
          busy_d[p]  = 1'b0;
        end else if (wr_hit) begin
          rdata_d[p] = wr_data;
          busy_d[p]  = claim_hit;
        end else begin
          rdata_d[p] = mem_q[raddr[p]];
          busy_d[p]  = pending[raddr[p]];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      rdata_q    <= '{default: '0};
      busy_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data1 = rdata_q[0];
  assign rd_data2 = rdata_q[1];
  assign busy1    = busy_q[0];
  assign busy2    = busy_q[1];
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Self-checking bench for regfile_2r1w_sb (default parameters) with a
// behavioural array model of registers and pending bits.
module tb_regfile_2r1w_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        rd_valid, busy1, busy2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic        claim_conflict;
  logic [31:0] pending;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state and expected registered outputs.
  logic [31:0] m_mem  [32];
  bit          m_pend [32];
  logic [31:0] e_rd1, e_rd2;
  logic        e_b1, e_b2, e_rv, e_cc;

  regfile_2r1w_sb dut (
    .clk            (clk),
    .rst            (rst),
    .rd_en          (rd_en),
    .rd_addr1       (rd_addr1),
    .rd_addr2       (rd_addr2),
    .rd_data1       (rd_data1),
    .rd_data2       (rd_data2),
    .rd_valid       (rd_valid),
    .busy1          (busy1),
    .busy2          (busy2),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .claim_en       (claim_en),
    .claim_addr     (claim_addr),
    .claim_conflict (claim_conflict),
    .pending        (pending)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 0;
    end
    e_rd1 = '0; e_rd2 = '0; e_b1 = 0; e_b2 = 0; e_rv = 0; e_cc = 0;
  endtask

  function automatic logic [31:0] model_data(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return '0;
    if (we && wa == a) return wd;
    return m_mem[a];
  endfunction

  function automatic logic model_busy(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                      input logic ce, input logic [4:0] ca);
    if (a == 0) return 1'b0;
    if (we && wa == a) return ce && ca == a;
    return m_pend[a];
  endfunction

  // Apply one cycle of inputs, advance the model across the edge, settle #1.
  task automatic step(input logic re, input logic [4:0] a1, input logic [4:0] a2,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ce, input logic [4:0] ca);
    rd_en = re; rd_addr1 = a1; rd_addr2 = a2;
    wr_en = we; wr_addr = wa; wr_data = wd;
    claim_en = ce; claim_addr = ca;
    @(posedge clk);
    e_rv = re;
    if (re) begin
      e_rd1 = model_data(a1, we, wa, wd);
      e_rd2 = model_data(a2, we, wa, wd);
      e_b1  = model_busy(a1, we, wa, ce, ca);
      e_b2  = model_busy(a2, we, wa, ce, ca);
    end
    e_cc = ce && ca != 0 && m_pend[ca] && !(we && wa == ca);
    if (we && wa != 0) begin
      m_mem[wa]  = wd;
      m_pend[wa] = 0;
    end
    if (ce && ca != 0) m_pend[ca] = 1;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_en = 0; rd_addr1 = 0; rd_addr2 = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    claim_en = 0; claim_addr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({rd_valid, pending, claim_conflict, rd_data1, busy1} !== {1'b0, 32'h0, 1'b0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: valid=%0b pending=%h cc=%0b rd1=%h busy1=%0b, required all zero",
               rd_valid, pending, claim_conflict, rd_data1, busy1);
    end
    #3 rst = 1'b0;
    step(1, 3, 31, 0, 0, 0, 0, 0);
    vectors++;
    if ({rd_valid, rd_data1, rd_data2, busy1, busy2} !== {1'b1, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_read: valid=%0b rd1=%h rd2=%h b1=%0b b2=%0b, required 1/0/0/0/0",
               rd_valid, rd_data1, rd_data2, busy1, busy2);
    end
  endtask

  task automatic test_write_read();
    step(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    step(1, 5, 3, 0, 0, 0, 0, 0);
    vectors++;
    if (rd_data1 !== 32'hDEADBEEF || rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL write_read: rd1=%h valid=%0b, required deadbeef/1", rd_data1, rd_valid);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (rd_valid !== 1'b0 || rd_data1 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL read_hold: valid=%0b rd1=%h, required 0/deadbeef", rd_valid, rd_data1);
    end
  endtask

  task automatic test_bypass();
    step(1, 7, 5, 1, 7, 32'h1234, 0, 0);
    vectors++;
    if (rd_data1 !== 32'h1234 || rd_data2 !== 32'hDEADBEEF || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass: rd1=%h rd2=%h b1=%0b, required 1234/deadbeef/0", rd_data1, rd_data2, busy1);
    end
  endtask

  task automatic test_zero_reg();
    step(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_read: rd1=%h rd2=%h, required 0/0", rd_data1, rd_data2);
    end
    step(1, 0, 0, 1, 0, 32'hA5A5A5A5, 1, 0);
    vectors++;
    if (pending[0] !== 1'b0 || rd_data1 !== 32'h0 || busy1 !== 1'b0 || claim_conflict !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_claim: pend0=%0b rd1=%h b1=%0b cc=%0b, required 0/0/0/0",
               pending[0], rd_data1, busy1, claim_conflict);
    end
  endtask

  task automatic test_scoreboard();
    step(0, 0, 0, 0, 0, 0, 1, 9);
    vectors++;
    if (pending !== 32'h0000_0200 || claim_conflict !== 1'b0) begin
      miscompares++;
      $display("FAIL claim_set: pending=%h cc=%0b, required 00000200/0", pending, claim_conflict);
    end
    step(1, 9, 9, 0, 0, 0, 0, 0);
    vectors++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_pending: b1=%0b b2=%0b, required 1/1", busy1, busy2);
    end
    step(1, 9, 0, 1, 9, 32'h55, 0, 0);
    vectors++;
    if (busy1 !== 1'b0 || rd_data1 !== 32'h55 || pending[9] !== 1'b0) begin
      miscompares++;
      $display("FAIL write_clears: b1=%0b rd1=%h pend9=%0b, required 0/55/0", busy1, rd_data1, pending[9]);
    end
    step(1, 9, 0, 1, 9, 32'h66, 1, 9);
    vectors++;
    if (pending[9] !== 1'b1 || claim_conflict !== 1'b0 || busy1 !== 1'b1 || rd_data1 !== 32'h66) begin
      miscompares++;
      $display("FAIL claim_and_write: pend9=%0b cc=%0b b1=%0b rd1=%h, required 1/0/1/66",
               pending[9], claim_conflict, busy1, rd_data1);
    end
    step(1, 9, 0, 0, 0, 0, 1, 9);
    vectors++;
    if (claim_conflict !== 1'b1 || pending[9] !== 1'b1 || busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL conflict_pulse: cc=%0b pend9=%0b b1=%0b, required 1/1/1", claim_conflict, pending[9], busy1);
    end
    idle();
    vectors++;
    if (claim_conflict !== 1'b0 || pending[9] !== 1'b1) begin
      miscompares++;
      $display("FAIL conflict_one_cycle: cc=%0b pend9=%0b, required 0/1", claim_conflict, pending[9]);
    end
  endtask

  task automatic test_random();
    logic [4:0] a [4];
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) a[k] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 6)) : 5'($urandom);
      step(1'($urandom), a[0], a[1], 1'($urandom), a[2], $urandom,
           ($urandom_range(0, 2) == 0), a[3]);
      vectors++;
      if ({rd_valid, rd_data1, rd_data2, busy1, busy2, claim_conflict, pending} !==
          {e_rv, e_rd1, e_rd2, e_b1, e_b2, e_cc, pend_vec()}) begin
        miscompares++;
        $display("FAIL random[%0d]: got v=%0b d1=%h d2=%h b=%0b%0b cc=%0b p=%h, required v=%0b d1=%h d2=%h b=%0b%0b cc=%0b p=%h",
                 n, rd_valid, rd_data1, rd_data2, busy1, busy2, claim_conflict, pending,
                 e_rv, e_rd1, e_rd2, e_b1, e_b2, e_cc, pend_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1, 2, 4, 1, 2, 32'hCAFE0002, 1, 4);
    vectors++;
    if (pending[4] !== 1'b1 || rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: pend4=%0b valid=%0b, required 1/1", pending[4], rd_valid);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (pending !== 32'h0 || rd_valid !== 1'b0 || rd_data1 !== 32'h0 || claim_conflict !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: pending=%h valid=%0b rd1=%h cc=%0b, required 0/0/0/0",
               pending, rd_valid, rd_data1, claim_conflict);
    end
    #1 rst = 1'b0;
    idle();
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL valid_after_reset: valid=%0b, required 0", rd_valid);
    end
    step(1, 2, 4, 0, 0, 0, 0, 0);
    vectors++;
    if ({rd_valid, rd_data1, busy2} !== {1'b1, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL mem_cleared: valid=%0b rd1=%h b2=%0b, required 1/0/0", rd_valid, rd_data1, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_random();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
